// File: rtl/data_mem_stall.sv
// Data-memory / branch-resolve stage with multi-cycle access latency.
// A request is accepted in IDLE, waits MEM_LAT cycles with stall high, and
// completes in RESP. Halt lets any in-flight access finish, then pulses dump
// once and parks in HALTED until reset.
// Optional feature: define DMEM_ALIGN_CHK_EN to reject odd byte addresses
// (adds align_err_o and forces a halt on the offending request).
module data_mem_stall #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MEM_AW  = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              halt_i,
  input  logic              zero_i,
  input  logic              ltz_i,
  input  logic              branch_i,
  input  logic [1:0]        branch_op_i,
  input  logic [DATA_W-1:0] branch_addr_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic [DATA_W-1:0] branch_or_pc_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              stall_o,
  output logic              dump_o,
`ifdef DMEM_ALIGN_CHK_EN
  output logic              align_err_o,
`endif
  output logic              halted_o
);

  localparam int unsigned Depth = 1 << MEM_AW;

  typedef enum logic [1:0] {StIdle, StWait, StResp, StHalted} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   rdata_q;
  logic                dump_q, dump_d;
  logic                err_d;
  logic                commit;
  logic                req;
  logic                misalign;
  logic                cond;
  logic [DATA_W-1:0]   mem_q [Depth];

  // Only the word-index bits of the address select storage; the rest alias.
  logic unused_addr;
  assign unused_addr = ^{addr_i[DATA_W-1:MEM_AW+1], addr_i[0]};

  assign req = mem_read_i | mem_write_i;

`ifdef DMEM_ALIGN_CHK_EN
  assign misalign = addr_i[0];
`else
  assign misalign = 1'b0;
`endif

  // Branch condition decode and next-PC select.
  always_comb begin
    cond = 1'b0;
    unique case (branch_op_i)
      2'b00:   cond = zero_i;
      2'b01:   cond = ~zero_i;
      2'b10:   cond = ltz_i;
      default: cond = ~ltz_i;
    endcase
    branch_or_pc_o = (branch_i & cond) ? branch_addr_i : pc_i;
  end

  // Access FSM next-state, request latching and stall generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    pend_d  = pend_q;
    stall_o = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && !misalign) begin
          addr_d  = addr_i[MEM_AW:1];
          wdata_d = wdata_i;
          we_d    = mem_write_i;
          cnt_d   = 4'(MEM_LAT - 1);
          pend_d  = halt_i;
          stall_o = 1'b1;
          state_d = (MEM_LAT > 1) ? StWait : StResp;
        end else if (req) begin
          err_d   = 1'b1;
          state_d = StHalted;
        end else if (halt_i) begin
          state_d = StHalted;
        end
      end
      StWait: begin
        stall_o = 1'b1;
        pend_d  = pend_q | halt_i;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp: begin
        pend_d  = 1'b0;
        state_d = pend_q ? StHalted : StIdle;
      end
      default: ;
    endcase
    // Storage and rdata update on the edge that enters RESP; the *_d values
    // hold the access even when MEM_LAT=1 skips WAIT.
    commit = (state_d == StResp);
    dump_d = (state_d == StHalted) && (state_q != StHalted);
  end

  // FSM and latched-request registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      dump_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      dump_q  <= dump_d;
    end
  end

  // Storage array and load-data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else if (commit) begin
      if (we_d) mem_q[addr_d] <= wdata_d;
      else      rdata_q       <= mem_q[addr_d];
    end
  end

`ifdef DMEM_ALIGN_CHK_EN
  logic align_q;
  // One-cycle misaligned-request flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) align_q <= 1'b0;
    else     align_q <= err_d;
  end
  assign align_err_o = align_q;
`endif

  assign rdata_o       = rdata_q;
  assign rdata_valid_o = (state_q == StResp) && !we_q;
  assign dump_o        = dump_q;
  assign halted_o      = (state_q == StHalted);

endmodule

// File: tb/tb_data_mem_stall.sv
// Directed bench: one instance with MEM_LAT=3 and one with MEM_LAT=2, both
// fed the same stimulus.
module tb_data_mem_stall;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, halt = 1'b0;
  logic        zero = 1'b0, ltz = 1'b0, branch = 1'b0;
  logic [1:0]  branch_op = 2'b00;
  logic [15:0] addr = '0, wdata = '0, branch_addr = '0, pc = '0;

  logic [15:0] bpc3, rdata3, bpc2, rdata2;
  logic        valid3, stall3, dump3, halted3;
  logic        valid2, stall2, dump2, halted2;
`ifdef DMEM_ALIGN_CHK_EN
  logic        aerr3, aerr2;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_stall #(.DATA_W(16), .MEM_AW(8), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .addr_i(addr), .wdata_i(wdata), .halt_i(halt), .zero_i(zero), .ltz_i(ltz),
    .branch_i(branch), .branch_op_i(branch_op), .branch_addr_i(branch_addr), .pc_i(pc),
    .branch_or_pc_o(bpc3), .rdata_o(rdata3), .rdata_valid_o(valid3), .stall_o(stall3),
    .dump_o(dump3),
`ifdef DMEM_ALIGN_CHK_EN
    .align_err_o(aerr3),
`endif
    .halted_o(halted3)
  );

  data_mem_stall #(.DATA_W(16), .MEM_AW(8), .MEM_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .addr_i(addr), .wdata_i(wdata), .halt_i(halt), .zero_i(zero), .ltz_i(ltz),
    .branch_i(branch), .branch_op_i(branch_op), .branch_addr_i(branch_addr), .pc_i(pc),
    .branch_or_pc_o(bpc2), .rdata_o(rdata2), .rdata_valid_o(valid2), .stall_o(stall2),
    .dump_o(dump2),
`ifdef DMEM_ALIGN_CHK_EN
    .align_err_o(aerr2),
`endif
    .halted_o(halted2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the MEM_LAT=3 instance: request in cycle 0, sampled for
  // cycles 0..3 (RESP is cycle 3). Returns per-cycle stall/valid masks.
  task automatic access3(input logic wr, input logic [15:0] a, input logic [15:0] d,
                         output logic [31:0] st_m, output logic [31:0] vl_m,
                         output logic [31:0] rd);
    st_m = '0;
    vl_m = '0;
    rd   = 32'hdead;
    @(posedge clk); #1;
    mem_write = wr;
    mem_read  = ~wr;
    addr      = a;
    wdata     = d;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      st_m[k] = stall3;
      vl_m[k] = valid3;
      if (valid3) rd = 32'(rdata3);
      if (k < 3) begin
        @(posedge clk); #1;
        mem_write = 1'b0;
        mem_read  = 1'b0;
      end
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic        br;
    logic [1:0]  op;
    logic        z;
    logic        l;
    logic [15:0] exp;
  } bvec_t;

  initial begin
    logic [31:0] st, vl, rd;
    logic [31:0] m_st, m_vl, m_dp, m_hl, m_ae;
    bvec_t bv [8];

    // Reset state
    #12;
    check_eq("rst_stall", 32'(stall3), 32'h0);
    check_eq("rst_rdata", 32'(rdata3), 32'h0);
    check_eq("rst_valid", 32'(valid3), 32'h0);
    check_eq("rst_dump", 32'(dump3), 32'h0);
    check_eq("rst_halted", 32'(halted3), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-WAIT discards the pending store
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 16'h0010; wdata = 16'hbeef;
    @(negedge clk);
    check_eq("rstw_acc_stall", 32'(stall3), 32'h1);
    @(posedge clk); #1;
    mem_write = 1'b0;
    @(negedge clk);
    check_eq("rstw_wait_stall", 32'(stall3), 32'h1);
    #1 rst = 1'b1;
    #1;
    check_eq("rstw_async_stall3", 32'(stall3), 32'h0);
    check_eq("rstw_async_stall2", 32'(stall2), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    access3(1'b0, 16'h0010, 16'h0, st, vl, rd);
    check_eq("rstw_load_valid", vl, 32'h8);
    check_eq("rstw_load_rdata", rd, 32'h0);

    // Store then back-to-back load, stall for exactly three cycles
    access3(1'b1, 16'h0020, 16'h1234, st, vl, rd);
    check_eq("st_stall_mask", st, 32'h7);
    check_eq("st_valid_mask", vl, 32'h0);
    access3(1'b0, 16'h0020, 16'h0, st, vl, rd);
    check_eq("ld_stall_mask", st, 32'h7);
    check_eq("ld_valid_mask", vl, 32'h8);
    check_eq("ld_rdata", rd, 32'h1234);

    // Store to another word leaves rdata alone; then read it back
    access3(1'b1, 16'h0030, 16'h5555, st, vl, rd);
    check_eq("hold_valid_mask", vl, 32'h0);
    check_eq("hold_rdata", 32'(rdata3), 32'h1234);
    access3(1'b0, 16'h0030, 16'h0, st, vl, rd);
    check_eq("ld2_rdata", rd, 32'h5555);
    access3(1'b0, 16'h0021, 16'h0, st, vl, rd);
    check_eq("ld_odd_ignored", rd, 32'h1234);

    // Address alias through upper bits
    access3(1'b1, 16'h0002, 16'haaaa, st, vl, rd);
    access3(1'b0, 16'h0202, 16'h0, st, vl, rd);
    check_eq("alias_rdata", rd, 32'haaaa);

    // Branch sweep (combinational)
    pc = 16'h0040;
    branch_addr = 16'h0100;
    bv[0] = '{1'b1, 2'b00, 1'b1, 1'b0, 16'h0100};
    bv[1] = '{1'b1, 2'b01, 1'b1, 1'b0, 16'h0040};
    bv[2] = '{1'b1, 2'b10, 1'b0, 1'b1, 16'h0100};
    bv[3] = '{1'b1, 2'b11, 1'b0, 1'b1, 16'h0040};
    bv[4] = '{1'b1, 2'b00, 1'b0, 1'b0, 16'h0040};
    bv[5] = '{1'b1, 2'b01, 1'b0, 1'b0, 16'h0100};
    bv[6] = '{1'b1, 2'b10, 1'b0, 1'b0, 16'h0040};
    bv[7] = '{1'b1, 2'b11, 1'b0, 1'b0, 16'h0100};
    for (int i = 0; i < 8; i++) begin
      branch = bv[i].br; branch_op = bv[i].op; zero = bv[i].z; ltz = bv[i].l;
      #1;
      check_eq($sformatf("br_vec%0d", i), 32'(bpc3), 32'(bv[i].exp));
    end
    // branch=0 with each op's condition true still selects pc
    branch = 1'b0;
    for (int op = 0; op < 4; op++) begin
      branch_op = 2'(op);
      zero = (op == 0);
      ltz  = (op == 2);
      #1;
      check_eq($sformatf("br_off_op%0d", op), 32'(bpc3), 32'h0040);
    end
    zero = 1'b0; ltz = 1'b0; branch_op = 2'b00;

    // Halt arriving with a load (MEM_LAT=2 instance)
    reset_pulse();
    access3(1'b1, 16'h0044, 16'h7777, st, vl, rd);
    @(posedge clk); #1;
    mem_read = 1'b1; halt = 1'b1; addr = 16'h0044;
    m_st = '0; m_vl = '0; m_dp = '0; m_hl = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      m_st[k] = stall2; m_vl[k] = valid2; m_dp[k] = dump2; m_hl[k] = halted2;
      if (k == 2) check_eq("halt_rdata", 32'(rdata2), 32'h7777);
      @(posedge clk); #1;
      mem_read = 1'b0; halt = 1'b0;
    end
    check_eq("halt_stall_mask", m_st, 32'h03);
    check_eq("halt_valid_mask", m_vl, 32'h04);
    check_eq("halt_dump_mask", m_dp, 32'h08);
    check_eq("halt_halted_mask", m_hl, 32'h38);
    // Requests after halt are ignored
    mem_write = 1'b1; addr = 16'h0044; wdata = 16'h1111;
    @(posedge clk); #1;
    mem_write = 1'b0; mem_read = 1'b1;
    m_st = '0; m_vl = '0; m_dp = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_st[k] = stall2; m_vl[k] = valid2; m_dp[k] = dump2;
      @(posedge clk); #1;
    end
    mem_read = 1'b0;
    check_eq("hlt_ign_stall", m_st, 32'h0);
    check_eq("hlt_ign_valid", m_vl, 32'h0);
    check_eq("hlt_ign_dump", m_dp, 32'h0);
    check_eq("hlt_ign_rdata", 32'(rdata2), 32'h7777);
    check_eq("hlt_sticky", 32'(halted2), 32'h1);

`ifdef DMEM_ALIGN_CHK_EN
    // Misaligned load is rejected and halts the block
    reset_pulse();
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 16'h0003;
    m_st = '0; m_ae = '0; m_dp = '0; m_hl = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_st[k] = stall3; m_ae[k] = aerr3; m_dp[k] = dump3; m_hl[k] = halted3;
      @(posedge clk); #1;
      mem_read = 1'b0;
    end
    check_eq("al_stall_mask", m_st, 32'h0);
    check_eq("al_err_mask", m_ae, 32'h2);
    check_eq("al_dump_mask", m_dp, 32'h2);
    check_eq("al_halted_mask", m_hl, 32'he);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
